led_pattern_gen: RTL and testbench

//   Parametrised LED pattern engine driven from the alta_boot internal oscillator clock.

---
 rtl/led_pattern_gen.sv | 140 ++++++++++++++
 tb/tb_led_pattern_gen.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen.sv
// LED pattern engine: prescaled step tick drives binary, Gray, scanner or PWM-breathing patterns
// onto registered, active-high LED outputs.
module led_pattern_gen #(
    parameter int unsigned N_LEDS     = 8,
    parameter int unsigned PRESCALE_W = 18,
    parameter int unsigned PWM_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [1:0]        mode,
    output logic [N_LEDS-1:0] leds,
    output logic              tick_o
);

    localparam int unsigned       PosW    = $clog2(N_LEDS);
    localparam logic [PosW-1:0]   PosMax  = PosW'(N_LEDS - 1);
    localparam logic [PWM_W-1:0]  DutyMax = '1;

    typedef enum logic [1:0] {
        ModeBin    = 2'd0,
        ModeGray   = 2'd1,
        ModeScan   = 2'd2,
        ModeBreath = 2'd3
    } mode_e;

    typedef enum logic {
        DirUp   = 1'b0,
        DirDown = 1'b1
    } dir_e;

    logic [PRESCALE_W-1:0] pre_q, pre_d;
    logic [PWM_W-1:0]      pwm_q, pwm_d;
    logic [PWM_W-1:0]      duty_q, duty_d;
    logic [N_LEDS-1:0]     cnt_q, cnt_d;
    logic [PosW-1:0]       pos_q, pos_d;
    dir_e                  dir_q, dir_d;
    mode_e                 mode_q;
    logic [N_LEDS-1:0]     leds_q, leds_d;
    logic                  tick_q;
    logic                  tick;
    logic                  mode_chg;

    assign tick     = en && (pre_q == '1);
    assign mode_chg = (mode_e'(mode) != mode_q);

    always_comb begin
        pre_d  = pre_q;
        pwm_d  = pwm_q;
        cnt_d  = cnt_q;
        pos_d  = pos_q;
        dir_d  = dir_q;
        duty_d = duty_q;
        leds_d = leds_q;

        if (en) begin
            pre_d = pre_q + 1'b1;
            pwm_d = pwm_q + 1'b1;
        end

        // A mode change restarts the pattern and swallows any coincident tick.
        if (mode_chg) begin
            cnt_d  = '0;
            pos_d  = '0;
            duty_d = '0;
            dir_d  = DirUp;
        end else if (tick) begin
            unique case (mode_q)
                ModeBin, ModeGray: cnt_d = cnt_q + 1'b1;
                ModeScan: begin
                    if (dir_q == DirUp) begin
                        if (pos_q == PosMax) begin
                            dir_d = DirDown;
                            pos_d = PosMax - PosW'(1);
                        end else begin
                            pos_d = pos_q + PosW'(1);
                        end
                    end else if (pos_q == '0) begin
                        dir_d = DirUp;
                        pos_d = PosW'(1);
                    end else begin
                        pos_d = pos_q - PosW'(1);
                    end
                end
                ModeBreath: begin
                    if (dir_q == DirUp) begin
                        if (duty_q == DutyMax) begin
                            dir_d  = DirDown;
                            duty_d = DutyMax - 1'b1;
                        end else begin
                            duty_d = duty_q + 1'b1;
                        end
                    end else if (duty_q == '0) begin
                        dir_d  = DirUp;
                        duty_d = PWM_W'(1);
                    end else begin
                        duty_d = duty_q - 1'b1;
                    end
                end
            endcase
        end

        if (en) begin
            unique case (mode_q)
                ModeBin:    leds_d = cnt_q;
                ModeGray:   leds_d = cnt_q ^ (cnt_q >> 1);
                ModeScan:   leds_d = N_LEDS'(1) << pos_q;
                ModeBreath: leds_d = {N_LEDS{pwm_q < duty_q}};
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q  <= '0;
            pwm_q  <= '0;
            cnt_q  <= '0;
            pos_q  <= '0;
            dir_q  <= DirUp;
            duty_q <= '0;
            mode_q <= ModeBin;
            leds_q <= '0;
            tick_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            pwm_q  <= pwm_d;
            cnt_q  <= cnt_d;
            pos_q  <= pos_d;
            dir_q  <= dir_d;
            duty_q <= duty_d;
            mode_q <= mode_e'(mode);
            leds_q <= leds_d;
            tick_q <= tick;
        end
    end

    assign leds   = leds_q;
    assign tick_o = tick_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: tick-count pattern model checked every cycle, plus directed
// literal sequences for each mode, async reset, enable freeze and mode-change discard.
module tb_led_pattern_gen;

    localparam int N  = 4;
    localparam int PW = 2;
    localparam int WW = 3;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         en    = 1'b0;
    logic [1:0]   mode  = 2'd0;
    logic [N-1:0] leds;
    logic         tick_o;

    led_pattern_gen #(
        .N_LEDS    (N),
        .PRESCALE_W(PW),
        .PWM_W     (WW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .mode  (mode),
        .leds  (leds),
        .tick_o(tick_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Model: output is a function of the mode, ticks since the last restart and enabled clocks.
    function automatic logic [N-1:0] pattern(input int md, input int k, input int clks);
        int p, d, b, per;
        case (md)
            0: return N'(k % (1 << N));
            1: begin
                b = k % (1 << N);
                return N'(b ^ (b >> 1));
            end
            2: begin
                per = 2 * (N - 1);
                p   = k % per;
                if (p >= N) p = per - p;
                return N'(1 << p);
            end
            default: begin
                per = 2 * ((1 << WW) - 1);
                p   = k % per;
                d   = (p < (1 << WW)) ? p : per - p;
                return ((clks % (1 << WW)) < d) ? '1 : '0;
            end
        endcase
    endfunction

    int           m_clks = 0;
    int           m_k    = 0;
    int           m_mq   = 0;
    logic [N-1:0] m_leds = '0;
    logic         m_tick = 1'b0;
    bit           m_t;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_clks = 0;
                m_k    = 0;
                m_mq   = 0;
                m_leds = '0;
                m_tick = 1'b0;
            end else begin
                m_t = en && ((m_clks % (1 << PW)) == (1 << PW) - 1);
                if (en) m_leds = pattern(m_mq, m_k, m_clks);
                m_tick = m_t;
                if (int'(mode) != m_mq) m_k = 0;
                else if (m_t) m_k++;
                if (en) m_clks++;
                m_mq = int'(mode);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("leds_vs_model", 32'(leds), 32'(m_leds));
            chk("tick_vs_model", 32'(tick_o), 32'(m_tick));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [N-1:0] tq[$];
    logic [N-1:0] lq[$];
    logic         h[$];
    logic         tk[$];

    task automatic do_reset(input logic [1:0] m);
        @(negedge clk);
        rst_n = 1'b0;
        mode  = m;
        en    = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Advance n clock edges, recording outputs after each and leds at every tick_o pulse.
    task automatic run(input int n);
        tq.delete(); lq.delete(); h.delete(); tk.delete();
        for (int e = 0; e < n; e++) begin
            @(posedge clk);
            @(negedge clk);
            lq.push_back(leds);
            h.push_back(leds[0]);
            tk.push_back(tick_o);
            if (tick_o) tq.push_back(leds);
        end
    endtask

    int exp_scan[9]  = '{1, 2, 4, 8, 4, 2, 1, 2, 4};
    int exp_gray[17] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0};
    int exp_br[16]   = '{0, 0, 0, 0, 15, 0, 15, 0, 15, 0, 15, 0, 0, 0, 0, 0};
    int bad, cnt, s;
    bit found;

    initial begin
        // Scanner sequence, no dwell at either end
        do_reset(2'd2);
        run(36);
        chk("scan_pulses", tq.size(), 9);
        for (int i = 0; i < 9 && i < tq.size(); i++) chk("scan_seq", 32'(tq[i]), exp_scan[i]);

        // Async reset mid-run while the scanner shows pos 2
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (leds == 4'd4) begin
                found = 1'b1;
                break;
            end
            @(posedge clk);
            @(negedge clk);
        end
        chk("scan_reach_pos2", 32'(found), 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_leds", 32'(leds), 0);
        chk("async_reset_tick", 32'(tick_o), 0);

        // Binary count and tick spacing
        do_reset(2'd0);
        run(68);
        chk("bin_pulses", tq.size(), 17);
        for (int i = 0; i < 17 && i < tq.size(); i++) chk("bin_seq", 32'(tq[i]), i % 16);
        bad = 0;
        cnt = 0;
        for (int e = 1; e <= 64; e++) begin
            if (tk[e-1] !== ((e % 4) == 0)) bad++;
            if (tk[e-1] === 1'b1) cnt++;
        end
        chk("tick_spacing_errors", bad, 0);
        chk("tick_count_64", cnt, 16);

        // Gray count, single-bit steps including the wrap
        do_reset(2'd1);
        run(68);
        chk("gray_pulses", tq.size(), 17);
        for (int i = 0; i < 17 && i < tq.size(); i++) chk("gray_seq", 32'(tq[i]), exp_gray[i]);
        bad = 0;
        for (int i = 1; i < tq.size(); i++) if ($countones(tq[i] ^ tq[i-1]) != 1) bad++;
        chk("gray_one_bit_steps", bad, 0);

        // Breathing: samples at tick pulses plus PWM duty windows
        do_reset(2'd3);
        run(68);
        for (int i = 0; i < 16 && i < tq.size(); i++) chk("breath_seq", 32'(tq[i]), exp_br[i]);
        s = 0;
        for (int i = 28; i < 36; i++) s += int'(h[i]);
        chk("breath_window_duty7", s, 7);
        s = 0;
        for (int i = 28; i < 32; i++) s += int'(h[i]);
        chk("breath_half_duty7", s, 3);
        s = 0;
        for (int i = 56; i < 60; i++) s += int'(h[i]);
        chk("breath_window_duty0", s, 0);

        // Enable freeze, then mode change landing on a tick edge
        do_reset(2'd0);
        run(10);
        chk("pre_freeze_leds", 32'(leds), 2);
        en = 1'b0;
        run(20);
        bad = 0;
        for (int i = 0; i < 20; i++) if (lq[i] !== 4'd2 || tk[i] !== 1'b0) bad++;
        chk("freeze_errors", bad, 0);
        en = 1'b1;
        run(1);
        mode = 2'd2;
        run(1);
        chk("switch_edge_leds", 32'(leds), 2);
        chk("switch_edge_tick", 32'(tick_o), 1);
        run(1);
        chk("switch_plus1_leds", 32'(leds), 1);
        run(3);
        bad = 0;
        for (int i = 0; i < 3; i++) if (lq[i] !== 4'd1) bad++;
        chk("discarded_tick_hold", bad, 0);
        run(1);
        chk("scan_after_switch", 32'(leds), 2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
